ex_mem_stage: RTL
=================

# ex_mem_stage

Pipeline register and condition-code unit directly downstream of the ALU. Each cycle it captures the ALU result, carry, destination and memory-control bits into the EX/MEM boundary. It derives Zero/Negative from the captured result and maintains the architectural flag register (CCR), which is fed back to the ALU `flags_in`. A small shadow stack saves and restores the CCR across interrupt entry and return.

## Interface

**Parameters**
- `WIDTH`, 16: datapath width.
- `REG_ADDR_W`, 3: destination register address width.
- `STACK_DEPTH`, 2: shadow flag stack entries (≥1).

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: hold all state.
- `flush` in 1: insert bubble.
- `valid_in` in 1: ALU stage holds a real instruction.
- `alu_result` in WIDTH: ALU result.
- `alu_carry` in 1: ALU carry out (ALU `flags_out[0]`).
- `flag_mask` in 3: per-flag update enable, {N,Z,C}.
- `dest_in` in REG_ADDR_W: writeback register.
- `reg_write_in`, `mem_read_in`, `mem_write_in` in 1 each: control bits.
- `store_data_in` in WIDTH: store operand.
- `int_save` in 1: push CCR onto shadow stack.
- `int_restore` in 1: pop shadow stack into CCR.
- `valid_out` out 1; `result_out` out WIDTH; `dest_out` out REG_ADDR_W.
- `reg_write_out`, `mem_read_out`, `mem_write_out` out 1 each.
- `store_data_out` out WIDTH.
- `flags` out 3: CCR, {N,Z,C}, bit 0 = C; drives ALU `flags_in`.
- `stack_ovf`, `stack_unf` out 1 each: sticky error flags.

## Operation

- **Flags:** Z = (`alu_result` == 0); N = `alu_result[WIDTH-1]`; C = `alu_carry`.
- **Normal load:** no `rst`, no `flush`, no `stall`. All pipeline outputs load from inputs and `valid_out` ← `valid_in`.
- **Flag update:** if `valid_in`=1, each CCR bit with `flag_mask` bit set loads its new value; unmasked bits hold. If `valid_in`=0, the CCR holds.
- **Flush:** `valid_out`, `reg_write_out`, `mem_read_out` and `mem_write_out` ← 0. `result_out`, `dest_out` and `store_data_out` ← 0. The CCR does not update from the ALU.
- **Stall:** every register holds, including the CCR, the stack and the error flags. `int_save`/`int_restore` are ignored.
- **Priority:** `rst` > `flush` > `stall` > normal.
- **Shadow stack:** LIFO of STACK_DEPTH × 3 bits, with `count` from 0 to STACK_DEPTH.
  - `int_save`: push the CCR value being written this edge, i.e. the post-update value. `count`+1.
  - `int_restore`: CCR ← top entry; `count`−1. Restore overrides any ALU flag update on the same edge.
  - `int_save` and `int_restore` together: both ignored; the CCR updates normally.
  - Push when full: no write, `count` holds, `stack_ovf` ← 1.
  - Pop when empty: CCR follows the normal update, `stack_unf` ← 1.
  - `stack_ovf`/`stack_unf` clear only on `rst`.
- Save/restore are honoured during `flush` (interrupt entry normally flushes); they are not honoured during `stall`.

## Timing

- **Latency:** every output is registered. Inputs sampled at edge *n* appear after edge *n*; latency is 1 cycle.
- **Flag forwarding:** `flags` reflects an instruction's update from the cycle after its capture edge. The next ALU op sees the updated flags with no bypass; back-to-back flag-dependent ops are correct.
- **Reset:** on the first edge with `rst`=1, all outputs are 0: `valid_out`, `result_out`, `dest_out`, the control outputs, `store_data_out`, `flags`=3'b000, `count`=0, `stack_ovf`=0, `stack_unf`=0.
- **Reset mid-operation:** discards the in-flight instruction and all stacked flags.
- **No combinational paths** from inputs to outputs.

## Configuration

- **`SHADOW_FLAGS_EN` defined:** the shadow stack, `int_save`, `int_restore`, `stack_ovf` and `stack_unf` behave as above.
- **Not defined:** no stack storage is built. `int_save`/`int_restore` are ignored, `stack_ovf`=`stack_unf`=0 constantly, and the CCR follows only the ALU update rules.
- Ports are present in both builds.

## Test plan

- **Reset then capture:** `rst` 1 cycle, then `valid_in`=1, `alu_result`=16'h8000, `alu_carry`=1, `flag_mask`=3'b111, `dest_in`=5, `reg_write_in`=1 → next cycle `result_out`=16'h8000, `dest_out`=5, `reg_write_out`=1, `flags`=3'b101.
- **Mask and zero:** `alu_result`=0, `alu_carry`=0, `flag_mask`=3'b010 from `flags`=3'b101 → `flags`=3'b111.
- **Stall vs flush:** load 16'h1234; assert `stall` 3 cycles with changing inputs → outputs hold 16'h1234. Then assert `stall`+`flush` together → `valid_out`=0, all controls 0, `flags` unchanged.
- **Save/restore:** set `flags`=3'b001; `int_save`; ALU op sets `flags`=3'b010; `int_restore` concurrent with `valid_in` and `flag_mask`=3'b111 → `flags`=3'b001.
- **Stack limits (STACK_DEPTH=2):** three saves → `stack_ovf`=1 and the first two entries are intact. Three restores → `flags` returns the 2nd then the 1st saved value, and the third restore sets `stack_unf`=1.
- **Macro off:** same sequence as the save/restore scenario → `flags`=3'b010 after `int_restore`, and both error flags stay 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register plus condition-code unit.
// Captures the ALU result and control bits, maintains the {N,Z,C} flag
// register (CCR) fed back to the ALU, and optionally a shadow stack that
// saves/restores the CCR across interrupt entry and return.
// Optional feature macro: SHADOW_FLAGS_EN (shadow flag stack and its
// error flags are built only when defined).
module ex_mem_stage #(
  parameter int WIDTH       = 16,
  parameter int REG_ADDR_W  = 3,
  parameter int STACK_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_carry,
  input  logic [2:0]            flag_mask,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [WIDTH-1:0]      store_data_in,
  input  logic                  int_save,
  input  logic                  int_restore,
  output logic                  valid_out,
  output logic [WIDTH-1:0]      result_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic [WIDTH-1:0]      store_data_out,
  output logic [2:0]            flags,
  output logic                  stack_ovf,
  output logic                  stack_unf
);

  logic [2:0] ccr;
  logic [2:0] ccr_alu;   // CCR after the ALU update only
  logic [2:0] ccr_next;  // CCR after ALU update and any restore
  logic [2:0] fresh_flags;
  logic       advance;   // flush outranks stall, so a flush always moves state

  assign advance     = flush || !stall;
  assign fresh_flags = {alu_result[WIDTH-1], (alu_result == '0), alu_carry};

  // Masked ALU flag update; a bubble or a flush leaves the CCR alone.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ccr_alu = ccr;
    if (valid_in && !flush) begin
      ccr_alu = (ccr & ~flag_mask) | (fresh_flags & flag_mask);
    end
  end

  // EX/MEM pipeline register: reset, flush to a bubble, stall hold, or load.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_out      <= 1'b0;
      result_out     <= '0;
      dest_out       <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      store_data_out <= '0;
    end else if (!stall) begin
      valid_out      <= valid_in;
      result_out     <= alu_result;
      dest_out       <= dest_in;
      reg_write_out  <= reg_write_in;
      mem_read_out   <= mem_read_in;
      mem_write_out  <= mem_write_in;
      store_data_out <= store_data_in;
    end
  end

`ifdef SHADOW_FLAGS_EN
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(STACK_DEPTH);

  logic [2:0]       stack_mem [STACK_DEPTH];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] top;
  logic             save_req;
  logic             restore_req;
  logic             do_push;
  logic             do_pop;

  assign save_req    = int_save && !int_restore;
  assign restore_req = int_restore && !int_save;
  assign top         = count - 1'b1;

  // Stack decode: a restore from a non-empty stack overrides the ALU update.
  always_comb begin
    ccr_next = ccr_alu;
    do_push  = save_req && (count != FULL);
    do_pop   = restore_req && (count != '0);
    if (do_pop) begin
      ccr_next = stack_mem[top[IDX_W-1:0]];
    end
  end

  // Stack occupancy and sticky overflow/underflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else if (advance) begin
      if (do_push) count <= count + 1'b1;
      if (do_pop)  count <= count - 1'b1;
      if (save_req && !do_push)    stack_ovf <= 1'b1;
      if (restore_req && !do_pop)  stack_unf <= 1'b1;
    end
  end

  // Stack storage; the pushed value is the post-ALU-update CCR.
  // NOTE: the entries are not reset - count is, so stale data is never read.
  always_ff @(posedge clk) begin
    if (!rst && advance && do_push) begin
      stack_mem[count[IDX_W-1:0]] <= ccr_alu;
    end
  end
`else
  logic unused_shadow;

  assign unused_shadow = ^{int_save, int_restore};
  assign ccr_next      = ccr_alu;
  assign stack_ovf     = 1'b0;
  assign stack_unf     = 1'b0;
`endif

  // Architectural flag register, held on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccr <= 3'b000;
    end else if (advance) begin
      ccr <= ccr_next;
    end
  end

  assign flags = ccr;

endmodule
